// File: rtl/maze_port_rx.sv
// MAZE per-direction receive arbiter: QoS + round-robin + anti-starvation pick of 7 links into a small FIFO.
// Latency 1 cycle accept-to-out_vld; in_rdy drops only when the FIFO is full (never depends on out_rdy).
module maze_port_rx #(
    parameter int NUM_IN     = 7,
    parameter int PKT_W      = 23,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_vld,
    output logic [NUM_IN-1:0]       in_rdy,
    input  logic [NUM_IN*PKT_W-1:0] in_pkt,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [PKT_W-1:0]        out_pkt,
    output logic [15:0]             acc_cnt
);

    localparam int PW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int SW      = $clog2(STARVE_LIM + 1);
    localparam int QOS_BIT = PKT_W - 3;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIM_C   = SW'(STARVE_LIM);
    localparam logic [PW-1:0] LAST_IN = PW'(NUM_IN - 1);
    localparam logic [AW-1:0] LAST_FI = AW'(FIFO_DEPTH - 1);

    logic [NUM_IN-1:0] hreq, lreq;
    logic [PW:0]       hpick, lpick;
    logic              any_h, any_l, use_low, g_any, can_acc, accept, pop;
    logic [PW-1:0]     g_idx;
    logic [PKT_W-1:0]  g_pkt;

    logic [PW-1:0]    hptr_q, hptr_d, lptr_q, lptr_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      acc_q, acc_d;
    logic [PKT_W-1:0] mem_q [FIFO_DEPTH];

    // Returns {found, index}; scanning far-to-near lets the entry nearest the pointer win.
    function automatic logic [PW:0] rr_pick(input logic [NUM_IN-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_IN) j = j - NUM_IN;
            if (req[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        hreq = '0;
        lreq = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            hreq[i] = in_vld[i] &  in_pkt[i*PKT_W + QOS_BIT];
            lreq[i] = in_vld[i] & ~in_pkt[i*PKT_W + QOS_BIT];
        end
    end

    assign hpick   = rr_pick(hreq, hptr_q);
    assign lpick   = rr_pick(lreq, lptr_q);
    assign any_h   = |hreq;
    assign any_l   = |lreq;
    assign use_low = any_l & (~any_h | (starve_q == LIM_C));
    assign g_any   = use_low ? lpick[PW] : hpick[PW];
    assign g_idx   = use_low ? lpick[PW-1:0] : hpick[PW-1:0];
    assign g_pkt   = in_pkt[g_idx*PKT_W +: PKT_W];
    assign can_acc = (cnt_q < DEPTH_C) & ~rst;
    assign accept  = g_any & can_acc;
    assign in_rdy  = accept ? (NUM_IN'(1) << g_idx) : '0;
    assign out_vld = (cnt_q != '0);
    assign pop     = out_vld & out_rdy;
    assign out_pkt = mem_q[rd_q];
    assign acc_cnt = acc_q;

    always_comb begin
        hptr_d   = hptr_q;
        lptr_d   = lptr_q;
        starve_d = starve_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        if (accept) begin
            if (use_low) lptr_d = (g_idx == LAST_IN) ? '0 : g_idx + 1'b1;
            else         hptr_d = (g_idx == LAST_IN) ? '0 : g_idx + 1'b1;
            wr_d = (wr_q == LAST_FI) ? '0 : wr_q + 1'b1;
            if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
        end
        // Nobody is waiting in the low class, so there is nothing to protect.
        if (!any_l)
            starve_d = '0;
        else if (accept)
            starve_d = use_low ? '0 : ((starve_q == LIM_C) ? LIM_C : starve_q + 1'b1);
        if (pop) rd_d = (rd_q == LAST_FI) ? '0 : rd_q + 1'b1;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hptr_q   <= '0;
            lptr_q   <= '0;
            starve_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            hptr_q   <= hptr_d;
            lptr_q   <= lptr_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            if (accept) mem_q[wr_q] <= g_pkt;
        end
    end

endmodule

// File: tb/tb_maze_port_rx.sv
// Directed bench for maze_port_rx: vector table for reset/round-robin, hand sequences for QoS, backpressure, reset, saturation.
module tb_maze_port_rx;

    localparam int N  = 7;
    localparam int PW = 23;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_vld, in_rdy, qos_m;
    logic [N*PW-1:0] in_pkt;
    logic            out_vld, out_rdy;
    logic [PW-1:0]   out_pkt;
    logic [15:0]     acc_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic [6:0]  vld;
        logic [6:0]  qos;
        logic        ordy;
        logic [6:0]  exp_rdy;
        logic        exp_ovld;
        logic [7:0]  exp_data;
        logic [15:0] exp_acc;
    } vec_t;

    vec_t vecs [12];

    maze_port_rx #(.NUM_IN(7), .PKT_W(23), .FIFO_DEPTH(2), .STARVE_LIM(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_pkt  (in_pkt),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_pkt (out_pkt),
        .acc_cnt (acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk_pkt(input int i, input logic q);
        return {2'b01, q, 6'(i), 6'(i + 8), 8'(i)};
    endfunction

    always_comb begin
        in_pkt = '0;
        for (int i = 0; i < N; i++) in_pkt[i*PW +: PW] = mk_pkt(i, qos_m[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] v, input logic [6:0] q, input logic ordy);
        @(negedge clk);
        rst     = r;
        in_vld  = v;
        qos_m   = q;
        out_rdy = ordy;
        #1;
    endtask

    initial begin
        logic [6:0] bp_rdy [8];
        logic [7:0] bp_dat [8];
        int         prev;
        int         g;

        // rst vld qos ordy | in_rdy ovld data acc
        vecs[0]  = '{1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b0, 8'd0, 16'd0};
        vecs[1]  = '{1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b0, 8'd0, 16'd0};
        vecs[2]  = '{1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b0, 8'd0, 16'd0};
        vecs[3]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h01, 1'b0, 8'd0, 16'd0};
        vecs[4]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h02, 1'b1, 8'd0, 16'd1};
        vecs[5]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h04, 1'b1, 8'd1, 16'd2};
        vecs[6]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h08, 1'b1, 8'd2, 16'd3};
        vecs[7]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h10, 1'b1, 8'd3, 16'd4};
        vecs[8]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h20, 1'b1, 8'd4, 16'd5};
        vecs[9]  = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h40, 1'b1, 8'd5, 16'd6};
        vecs[10] = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h01, 1'b1, 8'd6, 16'd7};
        vecs[11] = '{1'b0, 7'h7F, 7'h00, 1'b1, 7'h02, 1'b1, 8'd0, 16'd8};

        bp_rdy = '{7'h00, 7'h04, 7'h08, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
        bp_dat = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};

        rst = 1'b1; in_vld = 7'h7F; qos_m = 7'h00; out_rdy = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].qos, vecs[i].ordy);
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_out_vld", i), 32'(out_vld), 32'(vecs[i].exp_ovld));
            if (vecs[i].exp_ovld)
                chk($sformatf("v%0d_out_data", i), 32'(out_pkt[7:0]), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_acc_cnt", i), 32'(acc_cnt), 32'(vecs[i].exp_acc));
        end

        // QoS: links 0-3 high, 4-6 low; eight high grants then one low, rotating the low winner.
        step(1'b1, 7'h7F, 7'h0F, 1'b1);
        chk("qos_rst_rdy", 32'(in_rdy), 32'd0);
        prev = -1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 9; k++) begin
                g = (k < 8) ? (k % 4) : (4 + r);
                step(1'b0, 7'h7F, 7'h0F, 1'b1);
                chk($sformatf("qos_r%0d_k%0d_rdy", r, k), 32'(in_rdy), 32'(1) << g);
                if (prev < 0) begin
                    chk("qos_first_out_vld", 32'(out_vld), 32'd0);
                end else begin
                    chk($sformatf("qos_r%0d_k%0d_out_vld", r, k), 32'(out_vld), 32'd1);
                    chk($sformatf("qos_r%0d_k%0d_out_pkt", r, k), 32'(out_pkt), 32'(mk_pkt(prev, prev < 4)));
                end
                prev = g;
            end
        end

        // Backpressure with a pending low request: pointers and starvation count must freeze while full.
        step(1'b1, 7'h7F, 7'h0F, 1'b0);
        step(1'b0, 7'h7F, 7'h0F, 1'b0);
        chk("bp_rdy0", 32'(in_rdy), 32'h01);
        chk("bp_ovld0", 32'(out_vld), 32'd0);
        step(1'b0, 7'h7F, 7'h0F, 1'b0);
        chk("bp_rdy1", 32'(in_rdy), 32'h02);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7'h7F, 7'h0F, 1'b0);
            chk($sformatf("bp_full%0d_rdy", i), 32'(in_rdy), 32'd0);
            chk($sformatf("bp_full%0d_acc", i), 32'(acc_cnt), 32'd2);
            chk($sformatf("bp_full%0d_head", i), 32'(out_pkt[7:0]), 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 7'h7F, 7'h0F, 1'b1);
            chk($sformatf("bp_drain%0d_rdy", j), 32'(in_rdy), 32'(bp_rdy[j]));
            chk($sformatf("bp_drain%0d_head", j), 32'(out_pkt[7:0]), 32'(bp_dat[j]));
        end

        // Mid-stream reset with a full FIFO.
        step(1'b1, 7'h7F, 7'h00, 1'b0);
        step(1'b0, 7'h7F, 7'h00, 1'b0);
        step(1'b0, 7'h7F, 7'h00, 1'b0);
        step(1'b0, 7'h7F, 7'h00, 1'b0);
        chk("mrst_full_ovld", 32'(out_vld), 32'd1);
        chk("mrst_full_rdy", 32'(in_rdy), 32'd0);
        step(1'b1, 7'h7F, 7'h00, 1'b0);
        chk("mrst_during_rdy", 32'(in_rdy), 32'd0);
        step(1'b0, 7'h7F, 7'h00, 1'b0);
        chk("mrst_after_ovld", 32'(out_vld), 32'd0);
        chk("mrst_after_acc", 32'(acc_cnt), 32'd0);
        chk("mrst_after_rdy", 32'(in_rdy), 32'h01);
        chk("mrst_after_pkt", 32'(out_pkt), 32'd0);

        // Accepted-packet counter saturation.
        step(1'b1, 7'h00, 7'h00, 1'b1);
        @(negedge clk);
        rst    = 1'b0;
        in_vld = 7'h00;
        force dut.acc_q = 16'hFFFE;
        #1;
        release dut.acc_q;
        #1;
        chk("sat_preload", 32'(acc_cnt), 32'hFFFE);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 7'h7F, 7'h00, 1'b1);
            chk($sformatf("sat_acc%0d", i), 32'(acc_cnt), (i == 0) ? 32'hFFFE : 32'hFFFF);
        end
        step(1'b0, 7'h00, 7'h00, 1'b1);
        chk("sat_hold", 32'(acc_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
